// File: rtl/network_pkg.sv
// Shared types and constants for the network sequencer slice.
package network_pkg;

  typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

  localparam int unsigned SETTLE_DEFAULT = 2;

  // Length of one network run for a given counter width.
  function automatic int unsigned run_cycles(input int unsigned width);
    return 32'd1 << (width + 32'd1);
  endfunction

endpackage

// File: rtl/network_sequencer_if.sv
// Frame-in / result-out handshake bundle between host and sequencer.
interface network_sequencer_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned HEIGHT = 7
) ();

  logic              in_valid;
  logic              in_ready;
  logic [HEIGHT-1:0] in_pixels;
  logic              res_valid;
  logic              res_ready;
  logic              res_fired;
  logic [WIDTH:0]    res_latency;
  logic              res_timeout;

  modport master (
    output in_valid, in_pixels, res_ready,
    input  in_ready, res_valid, res_fired, res_latency, res_timeout
  );

  modport slave (
    input  in_valid, in_pixels, res_ready,
    output in_ready, res_valid, res_fired, res_latency, res_timeout
  );

endinterface

// File: rtl/network_run_timer.sv
// Saturating run-cycle counter with registered settle and timeout flags.
module network_run_timer #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SETTLE  = 2,
  parameter int unsigned TIMEOUT = 520,
  parameter int unsigned CW      = $clog2(TIMEOUT + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           en,
  output logic [WIDTH:0] cnt,
  output logic           settled,
  output logic           timed_out
);

  localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);
  localparam logic [CW-1:0] LAST_C   = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign cnt = cnt_q[WIDTH:0];

  // Flags are computed from the next count so they line up with cnt_q.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      settled   <= (SETTLE == 0);
      timed_out <= (TIMEOUT == 1);
    end else begin
      cnt_q     <= cnt_d;
      settled   <= (cnt_d >= SETTLE_C);
      timed_out <= (cnt_d == LAST_C);
    end
  end

endmodule

// File: rtl/network_sequencer.sv
// Host-side initiator: latches a frame, starts the network run, returns one result per frame.
module network_sequencer
  import network_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned HEIGHT  = 7,
  parameter int unsigned SETTLE  = SETTLE_DEFAULT,
  parameter int unsigned TIMEOUT = run_cycles(WIDTH) + SETTLE + 6
) (
  input  logic              clk,
  input  logic              rst,
  network_sequencer_if.slave bus,
  output logic [HEIGHT-1:0] net_pixels,
  output logic              net_start,
  input  logic [1:0]        net_out,
  output logic              busy
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  state_t         state;
  logic           run_clr_c;
  logic           run_en_c;
  logic [WIDTH:0] run_cnt;
  logic           settled;
  logic           timed_out;

  assign run_clr_c = (state == START);
  assign run_en_c  = (state == RUN);

  network_run_timer #(
    .WIDTH   (WIDTH),
    .SETTLE  (SETTLE),
    .TIMEOUT (TIMEOUT),
    .CW      (CW)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr       (run_clr_c),
    .en        (run_en_c),
    .cnt       (run_cnt),
    .settled   (settled),
    .timed_out (timed_out)
  );

  // Sequencer FSM with registered handshake, network and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      bus.in_ready    <= 1'b1;
      bus.res_valid   <= 1'b0;
      bus.res_fired   <= 1'b0;
      bus.res_latency <= '0;
      bus.res_timeout <= 1'b0;
      net_pixels      <= '0;
      net_start       <= 1'b0;
      busy            <= 1'b0;
    end else begin
      net_start <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            net_pixels   <= bus.in_pixels;
            net_start    <= 1'b1;
            bus.in_ready <= 1'b0;
            busy         <= 1'b1;
            state        <= START;
          end
        end
        START: begin
          state <= RUN;
        end
        RUN: begin
          // Spike beats finish beats timeout when they coincide.
          if (net_out[0]) begin
            bus.res_fired   <= 1'b1;
            bus.res_timeout <= 1'b0;
            bus.res_latency <= run_cnt;
            bus.res_valid   <= 1'b1;
            state           <= DONE;
          end else if (net_out[1] && settled) begin
            bus.res_fired   <= 1'b0;
            bus.res_timeout <= 1'b0;
            bus.res_latency <= run_cnt;
            bus.res_valid   <= 1'b1;
            state           <= DONE;
          end else if (timed_out) begin
            bus.res_fired   <= 1'b0;
            bus.res_timeout <= 1'b1;
            bus.res_latency <= run_cnt;
            bus.res_valid   <= 1'b1;
            state           <= DONE;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_network_sequencer.sv
// Randomized and directed frames against an arithmetic model of the end-event rules.
module tb_network_sequencer;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned HEIGHT  = 7;
  localparam int unsigned SETTLE  = 2;
  localparam int unsigned TIMEOUT = (1 << (WIDTH + 1)) + SETTLE + 6;
  localparam int          NEVER   = 100000;

  logic              clk = 1'b0;
  logic              rst;
  logic [HEIGHT-1:0] net_pixels;
  logic              net_start;
  logic [1:0]        net_out;
  logic              busy;

  int passed = 0;
  int total  = 0;

  // Network environment: run-cycle index of first spike / first finish, and idle finish level.
  int sp_at    = NEVER;
  int fin_at   = NEVER;
  bit idle_fin = 1'b1;

  always #5 clk = ~clk;

  network_sequencer_if #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) bus ();

  network_sequencer #(
    .WIDTH   (WIDTH),
    .HEIGHT  (HEIGHT),
    .SETTLE  (SETTLE),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .net_pixels (net_pixels),
    .net_start  (net_start),
    .net_out    (net_out),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // First run cycle on which each rule could end the run; earliest wins, spike on ties.
  task automatic ref_result(input int sp, input int fin,
                            output int end_k, output bit fired, output bit tmo);
    int e_fin;
    e_fin = (fin < int'(SETTLE)) ? int'(SETTLE) : fin;
    end_k = int'(TIMEOUT) - 1;
    if (e_fin < end_k) end_k = e_fin;
    fired = (sp <= end_k);
    if (fired) end_k = sp;
    tmo = !fired && (e_fin != end_k) && (end_k == int'(TIMEOUT) - 1);
  endtask

  // Offer a frame at the current negedge; returns at the negedge of the START cycle.
  task automatic start_frame(input logic [HEIGHT-1:0] p);
    int w;
    w = 0;
    bus.in_valid  = 1'b1;
    bus.in_pixels = p;
    net_out       = {idle_fin, 1'b0};
    while (bus.in_ready !== 1'b1 && w < 16) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("start_pulse", 32'(net_start), 32'd1);
    chk("pixels_latched", 32'(net_pixels), 32'(p));
    chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
    chk("busy_set", 32'(busy), 32'd1);
  endtask

  // Play the network for each run cycle until a result appears or the bound expires.
  task automatic wait_result(input logic [HEIGHT-1:0] p, output int k,
                             output int starts, output int badpix);
    k = 0;
    starts = 0;
    badpix = 0;
    while (k <= int'(TIMEOUT) + 8) begin
      @(negedge clk);
      if (net_pixels !== p) badpix++;
      if (bus.res_valid === 1'b1) break;
      if (net_start !== 1'b0) starts++;
      net_out[1] = (k >= fin_at);
      net_out[0] = (k >= sp_at);
      k++;
    end
  endtask

  task automatic release_result(input int rd, input logic [HEIGHT-1:0] p);
    logic           f, t;
    logic [WIDTH:0] l;
    int             bad;
    f = bus.res_fired;
    t = bus.res_timeout;
    l = bus.res_latency;
    bad = 0;
    for (int i = 0; i < rd; i++) begin
      if (bus.res_fired !== f || bus.res_timeout !== t || bus.res_latency !== l ||
          bus.res_valid !== 1'b1 || bus.in_ready !== 1'b0 || net_pixels !== p) bad++;
      @(negedge clk);
    end
    chk("result_hold_stable", 32'(bad), 32'd0);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    net_out = {idle_fin, 1'b0};
    chk("res_valid_dropped", 32'(bus.res_valid), 32'd0);
    chk("in_ready_after_hs", 32'(bus.in_ready), 32'd1);
    chk("busy_cleared", 32'(busy), 32'd0);
    chk("pixels_until_idle", 32'(net_pixels), 32'(p));
  endtask

  task automatic run_case(input logic [HEIGHT-1:0] p, input int sp, input int fin,
                          input bit idle, input int rd, input bit preload,
                          input logic [HEIGHT-1:0] next_p);
    int k, starts, badpix, end_k;
    bit fired, tmo;
    sp_at = sp;
    fin_at = fin;
    idle_fin = idle;
    start_frame(p);
    wait_result(p, k, starts, badpix);
    ref_result(sp, fin, end_k, fired, tmo);
    chk("accept_to_valid", 32'(k + 2), 32'(end_k + 3));
    chk("res_fired", 32'(bus.res_fired), 32'(fired));
    chk("res_timeout", 32'(bus.res_timeout), 32'(tmo));
    chk("res_latency", 32'(bus.res_latency), 32'(end_k % (1 << (WIDTH + 1))));
    chk("no_extra_start", 32'(starts), 32'd0);
    chk("pixels_stable_run", 32'(badpix), 32'd0);
    if (preload) begin
      bus.in_valid  = 1'b1;
      bus.in_pixels = next_p;
    end
    release_result(rd, p);
  endtask

  initial begin
    int cnt;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_pixels = '0;
    bus.res_ready = 1'b0;
    net_out = 2'b10;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of a run.
    sp_at = NEVER; fin_at = NEVER; idle_fin = 1'b1;
    start_frame(HEIGHT'($urandom));
    repeat (20) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_net_start", 32'(net_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_net_pixels", 32'(net_pixels), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases.
    run_case(7'h7F, 40, NEVER, 1'b1, 0, 1'b0, '0);
    run_case(HEIGHT'($urandom), NEVER, 0, 1'b1, 0, 1'b0, '0);
    run_case(HEIGHT'($urandom), NEVER, 511, 1'b0, 1, 1'b0, '0);
    run_case(HEIGHT'($urandom), NEVER, NEVER, 1'b0, 0, 1'b0, '0);
    run_case(HEIGHT'($urandom), int'(TIMEOUT) - 1, NEVER, 1'b0, 0, 1'b0, '0);
    run_case(HEIGHT'($urandom), 30, 30, 1'b1, 0, 1'b0, '0);
    run_case(HEIGHT'($urandom), 0, 0, 1'b1, 0, 1'b0, '0);
    run_case(7'h2A, 17, NEVER, 1'b1, 10, 1'b1, 7'h55);
    run_case(7'h55, 3, 1, 1'b1, 0, 1'b0, '0);

    // Randomized frames.
    for (int i = 0; i < 8; i++) begin
      run_case(HEIGHT'($urandom), int'($urandom_range(0, 600)), int'($urandom_range(0, 600)),
               1'($urandom), int'($urandom_range(0, 3)), 1'b0, '0);
    end

    // Reset at cnt=100 abandons the frame; the next one runs normally.
    sp_at = NEVER; fin_at = NEVER; idle_fin = 1'b0;
    start_frame(HEIGHT'($urandom));
    repeat (101) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_res_valid", 32'(bus.res_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_net_pixels", 32'(net_pixels), 32'd0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.res_valid !== 1'b0) cnt++;
    end
    chk("abort_no_result", 32'(cnt), 32'd0);
    run_case(7'h0F, int'($urandom_range(0, 300)), NEVER, 1'b1, 1, 1'b0, '0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
